// File: rtl/processor_pkg.sv
// Shared types and instruction-field layout for the processor execution core.
package processor_pkg;

    localparam int REG_COUNT = 8;
    localparam int DATA_W    = 16;
    localparam int IMM_W     = 8;
    localparam int ADDR_W    = 3;
    localparam int OPC_W     = 3;
    localparam int NUM_OPND  = 4;
    localparam int INSTR_W   = 48;
    localparam int ALU_IN_W  = 3 * OPC_W + NUM_OPND * IMM_W;
    localparam int POW_EXP_W = 5;

    // Instruction word layout; operand k's select bit sits at OPND_TOP - k*OPND_STRIDE
    localparam int OP1_LSB     = 45;
    localparam int OP2_LSB     = 42;
    localparam int OP3_LSB     = 39;
    localparam int OPND_TOP    = 38;
    localparam int OPND_STRIDE = 9;
    localparam int DEST_LSB    = 0;

    typedef enum logic [OPC_W-1:0] {
        ALU_ADD  = 3'b000,
        ALU_AND  = 3'b001,
        ALU_MUL  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_POW  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_t;

    // opnd[0] is A (most significant), matching the {op1,op2,op3,A,B,C,D} bus
    typedef struct packed {
        alu_op_t                         op1;
        alu_op_t                         op2;
        alu_op_t                         op3;
        logic [0:NUM_OPND-1][IMM_W-1:0]  opnd;
    } alu_req_t;

endpackage

// File: rtl/processor_super_alu.sv
// Combinational three-operator ALU: out = op2(op1(A,B), op3(C,D)), all 16-bit wrapping.
module super_alu
    import processor_pkg::*;
(
    input  logic [ALU_IN_W-1:0] in,
    output logic [DATA_W-1:0]   out
);

    function automatic logic [DATA_W-1:0] alu_fn(input alu_op_t op,
                                                 input logic [DATA_W-1:0] l,
                                                 input logic [DATA_W-1:0] r);
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] base;
        acc  = '0;
        base = l;
        case (op)
            ALU_ADD:  acc = l + r;
            ALU_AND:  acc = l & r;
            ALU_MUL:  acc = l * r;
            ALU_SUB:  acc = l - r;
            ALU_POW: begin
                // Square-and-multiply over the 5 exponent bits; x**0 = 1 falls out naturally
                acc = 16'd1;
                for (int i = 0; i < POW_EXP_W; i++) begin
                    if (r[i]) acc = acc * base;
                    base = base * base;
                end
            end
            ALU_OR:   acc = l | r;
            ALU_XOR:  acc = l ^ r;
            default:  acc = l;
        endcase
        return acc;
    endfunction

    alu_req_t          req;
    logic [DATA_W-1:0] a, b, c, d, left, right;

    assign req   = alu_req_t'(in);
    assign a     = {{(DATA_W-IMM_W){1'b0}}, req.opnd[0]};
    assign b     = {{(DATA_W-IMM_W){1'b0}}, req.opnd[1]};
    assign c     = {{(DATA_W-IMM_W){1'b0}}, req.opnd[2]};
    assign d     = {{(DATA_W-IMM_W){1'b0}}, req.opnd[3]};
    assign left  = alu_fn(req.op1, a, b);
    assign right = alu_fn(req.op3, c, d);
    assign out   = alu_fn(req.op2, left, right);

endmodule

// File: rtl/processor.sv
// Execution core: operand muxes, 8x16 register file and registered result.
module processor
    import processor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] inp,
    input  logic               inp_valid,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid
);

    logic [REG_COUNT-1:0][DATA_W-1:0] regs;
    logic [0:NUM_OPND-1][IMM_W-1:0]   opnd;
    logic [ALU_IN_W-1:0]              alu_in;
    logic [DATA_W-1:0]                alu_out;
    logic [ADDR_W-1:0]                dest;

    // Register operands use only n[2:0]; the upper immediate bits are don't-care
    for (genvar k = 0; k < NUM_OPND; k++) begin : g_opnd
        localparam int SEL = OPND_TOP - k * OPND_STRIDE;
        logic             sel;
        logic [IMM_W-1:0] n;
        assign sel     = inp[SEL];
        assign n       = inp[SEL-1 -: IMM_W];
        assign opnd[k] = sel ? regs[n[ADDR_W-1:0]][IMM_W-1:0] : n;
    end

    assign alu_in = {inp[OP1_LSB +: OPC_W], inp[OP2_LSB +: OPC_W], inp[OP3_LSB +: OPC_W], opnd};
    assign dest   = inp[DEST_LSB +: ADDR_W];

    super_alu u_alu (
        .in  (alu_in),
        .out (alu_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            regs         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (inp_valid) begin
            regs[dest]   <= alu_out;
            result       <= alu_out;
            result_valid <= 1'b1;
        end else begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench for processor: reference model pushes expected results, outputs pop them.
module tb_processor;

    logic        clk = 1'b0;
    logic        rst;
    logic        inp_valid;
    logic [47:0] inp;
    logic [15:0] result;
    logic        result_valid;

    always #5 clk = ~clk;

    processor dut (
        .clk          (clk),
        .rst          (rst),
        .inp          (inp),
        .inp_valid    (inp_valid),
        .result       (result),
        .result_valid (result_valid)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_regs [8];
    logic [15:0] m_result;
    logic        m_valid;
    logic [15:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] l,
                                           input logic [15:0] r);
        logic [4:0]  e;
        logic [15:0] v;
        e = r[4:0];
        case (op)
            3'd0: v = l + r;
            3'd1: v = l & r;
            3'd2: v = l * r;
            3'd3: v = l - r;
            3'd4: v = l ** e;
            3'd5: v = l | r;
            3'd6: v = l ^ r;
            default: v = l;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] ref_opnd(input logic s, input logic [7:0] n);
        logic [15:0] rv;
        rv = m_regs[n[2:0]];
        return s ? rv[7:0] : n;
    endfunction

    function automatic logic [47:0] mk(input logic [2:0] o1, input logic [2:0] o2,
                                       input logic [2:0] o3,
                                       input logic s1, input logic [7:0] n1,
                                       input logic s2, input logic [7:0] n2,
                                       input logic s3, input logic [7:0] n3,
                                       input logic s4, input logic [7:0] n4,
                                       input logic [2:0] dst);
        return {o1, o2, o3, s1, n1, s2, n2, s3, n3, s4, n4, dst};
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), dut.regs[i], m_regs[i]);
    endtask

    // Drive one cycle, update the model with pre-edge register state, then check after the edge
    task automatic step(input logic r, input logic v, input logic [47:0] ins);
        logic [15:0] lhs, rhs, res;
        rst       = r;
        inp_valid = v;
        inp       = ins;
        lhs = ref_op(ins[47:45], {8'h0, ref_opnd(ins[38], ins[37:30])},
                                 {8'h0, ref_opnd(ins[29], ins[28:21])});
        rhs = ref_op(ins[41:39], {8'h0, ref_opnd(ins[20], ins[19:12])},
                                 {8'h0, ref_opnd(ins[11], ins[10:3])});
        res = ref_op(ins[44:42], lhs, rhs);
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
            m_result = 16'h0;
            m_valid  = 1'b0;
            sb.delete();
        end else if (v) begin
            m_regs[ins[2:0]] = res;
            m_result         = res;
            m_valid          = 1'b1;
            sb.push_back(res);
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("result_valid", result_valid, m_valid);
        if (result_valid) begin
            if (sb.size() == 0) chk("sb_underflow", result_valid, 1'b0);
            else chk("result_sb", result, sb.pop_front());
        end
        chk("result_hold", result, m_result);
        check_regs("step");
    endtask

    initial begin
        rst       = 1'b1;
        inp_valid = 1'b0;
        inp       = '0;
        m_result  = 16'h0;
        m_valid   = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'hx;

        step(1'b1, 1'b0, 48'h0);
        step(1'b1, 1'b0, 48'h0);
        chk("reset_result", result, 16'h0);
        chk("reset_valid", result_valid, 1'b0);

        step(1'b0, 1'b1, mk(3'b000, 3'b010, 3'b100, 0, 8'd12, 0, 8'd6, 0, 8'd2, 0, 8'd4, 3'd0));
        chk("mixed_ops", result, 16'd288);
        chk("mixed_reg0", dut.regs[0], 16'd288);

        step(1'b0, 1'b1, mk(3'b000, 3'b011, 3'b010, 0, 8'd10, 0, 8'd8, 0, 8'd3, 0, 8'd3, 3'd2));
        chk("sub_mul", result, 16'd9);
        chk("sub_mul_reg2", dut.regs[2], 16'd9);

        step(1'b0, 1'b1, mk(3'b000, 3'b000, 3'b000, 1, 8'd0, 0, 8'd1, 0, 8'd0, 0, 8'd0, 3'd3));
        chk("reg_operand", result, 16'd33);
        step(1'b0, 1'b1, mk(3'b000, 3'b000, 3'b000, 1, 8'd8, 0, 8'd1, 0, 8'd0, 0, 8'd0, 3'd3));
        chk("reg_operand_alias", result, 16'd33);

        step(1'b0, 1'b1, mk(3'b010, 3'b010, 3'b000, 0, 8'd255, 0, 8'd255, 0, 8'd2, 0, 8'd0, 3'd4));
        chk("wrap_mul", result, 16'hFC02);
        step(1'b0, 1'b1, mk(3'b000, 3'b011, 3'b010, 0, 8'd0, 0, 8'd0, 0, 8'd1, 0, 8'd1, 3'd5));
        chk("wrap_sub", result, 16'hFFFF);

        step(1'b0, 1'b1, mk(3'b111, 3'b000, 3'b100, 0, 8'd0, 0, 8'd0, 0, 8'd0, 0, 8'd0, 3'd6));
        chk("pow_0_0", result, 16'd1);
        step(1'b0, 1'b1, mk(3'b111, 3'b000, 3'b100, 0, 8'd0, 0, 8'd0, 0, 8'd3, 0, 8'd33, 3'd7));
        chk("pow_exp_trunc", result, 16'd3);

        step(1'b0, 1'b0, 48'hFFFF_FFFF_FFFF);
        chk("idle_valid", result_valid, 1'b0);
        chk("idle_hold", result, 16'd3);

        step(1'b0, 1'b1, mk(3'b000, 3'b000, 3'b000, 0, 8'd5, 0, 8'd0, 0, 8'd0, 0, 8'd0, 3'd1));
        step(1'b0, 1'b1, mk(3'b000, 3'b000, 3'b000, 1, 8'd1, 0, 8'd0, 0, 8'd0, 0, 8'd0, 3'd0));
        chk("b2b_forward", result, 16'd5);

        step(1'b1, 1'b1, mk(3'b000, 3'b000, 3'b000, 0, 8'd77, 0, 8'd1, 0, 8'd0, 0, 8'd0, 3'd2));
        chk("rst_pri_result", result, 16'h0);
        chk("rst_pri_valid", result_valid, 1'b0);
        chk("rst_pri_reg2", dut.regs[2], 16'h0);

        for (int t = 0; t < 80; t++) begin
            logic [47:0] ins;
            ins = {16'($urandom), 32'($urandom)};
            step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, ins);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
